// File: rtl/dram_responder_model.sv
// DRAM responder: decodes CSn/RASn/CASn/WEn commands on dram_clk rising edges
// (detected in top_clk), backs a small word store, returns reads after CAS_LAT.
// Ports: top_clk/top_rst, dram_clk, DRAM_* command/data in, DRAM_valid/DRAM_Q out,
//        row_open (row activated), proto_err (sticky protocol violation).
module dram_responder_model #(
  parameter int MEM_AW  = 6,
  parameter int COL_W   = 10,
  parameter int CAS_LAT = 5
) (
  input  logic        top_clk,
  input  logic        top_rst,
  input  logic        dram_clk,
  input  logic        DRAM_CSn,
  input  logic        DRAM_RASn,
  input  logic        DRAM_CASn,
  input  logic [3:0]  DRAM_WEn,
  input  logic [10:0] DRAM_A,
  input  logic [31:0] DRAM_D,
  output logic        DRAM_valid,
  output logic [31:0] DRAM_Q,
  output logic        row_open,
  output logic        proto_err
);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  localparam int AW_FULL = 11 + COL_W;
  localparam int DEPTH   = 2 ** MEM_AW;

  state_t       state;
  logic         dram_clk_q;
  logic [10:0]  row_q;
  logic [3:0]   lat_cnt;
  logic [31:0]  rd_data;
  logic [31:0]  mem [DEPTH];

  logic               dclk_rise;
  logic [AW_FULL-1:0] addr_full;
  logic [MEM_AW-1:0]  idx;
  logic               pipe_busy;
  logic               unused_ok;

  assign dclk_rise = dram_clk & ~dram_clk_q;
  assign addr_full = {row_q, DRAM_A[COL_W-1:0]};
  assign idx       = addr_full[MEM_AW-1:0];
  assign unused_ok = ^addr_full[AW_FULL-1:MEM_AW];
  assign row_open  = (state == ACTIVE);

  // lat_cnt==1 is the edge valid asserts; a new read may issue there.
  assign pipe_busy = (lat_cnt > 4'd1);

  always_ff @(posedge top_clk or posedge top_rst) begin
    if (top_rst) begin
      state      <= IDLE;
      dram_clk_q <= 1'b0;
      row_q      <= '0;
      lat_cnt    <= '0;
      rd_data    <= '0;
      DRAM_valid <= 1'b0;
      DRAM_Q     <= '0;
      proto_err  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      dram_clk_q <= dram_clk;
      if (dclk_rise) begin
        DRAM_valid <= (lat_cnt == 4'd1);
        if (lat_cnt == 4'd1) begin
          DRAM_Q <= rd_data;
        end
        if (lat_cnt != 4'd0) begin
          lat_cnt <= lat_cnt - 4'd1;
        end
        if (!DRAM_CSn) begin
          unique case (state)
            IDLE: begin
              if (!DRAM_RASn) begin
                if (DRAM_CASn) begin
                  row_q <= DRAM_A;
                  state <= ACTIVE;
                end else begin
                  proto_err <= 1'b1;
                end
              end
            end
            ACTIVE: begin
              if (DRAM_RASn) begin
                state <= IDLE;
              end else if (!DRAM_CASn) begin
                if (DRAM_WEn != 4'hF) begin
                  for (int b = 0; b < 4; b++) begin
                    if (!DRAM_WEn[b]) begin
                      mem[idx][8*b +: 8] <= DRAM_D[8*b +: 8];
                    end
                  end
                end else if (pipe_busy) begin
                  proto_err <= 1'b1;
                end else begin
                  // Snapshot now so later writes cannot alter the return.
                  rd_data <= mem[idx];
                  lat_cnt <= 4'(CAS_LAT);
                end
              end
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_dram_responder_model.sv
// Self-checking bench for dram_responder_model: scoreboard of expected reads
// (data + edge number) checked by a monitor, plus per-scenario inline checks.
module tb_dram_responder_model;

  localparam int CAS = 5;

  logic        top_clk;
  logic        top_rst;
  logic        dram_clk;
  logic        csn, rasn, casn;
  logic [3:0]  wen;
  logic [10:0] a;
  logic [31:0] d;
  logic        dram_valid;
  logic [31:0] dram_q;
  logic        row_open;
  logic        proto_err;

  typedef struct {
    logic [31:0] data;
    int          at;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   edge_n = 0;

  dram_responder_model #(
    .MEM_AW(6),
    .COL_W(10),
    .CAS_LAT(CAS)
  ) dut (
    .top_clk(top_clk),
    .top_rst(top_rst),
    .dram_clk(dram_clk),
    .DRAM_CSn(csn),
    .DRAM_RASn(rasn),
    .DRAM_CASn(casn),
    .DRAM_WEn(wen),
    .DRAM_A(a),
    .DRAM_D(d),
    .DRAM_valid(dram_valid),
    .DRAM_Q(dram_q),
    .row_open(row_open),
    .proto_err(proto_err)
  );

  initial top_clk = 1'b0;
  always #5 top_clk = ~top_clk;

  // Monitor: pop expectation on each valid rise, check pulse width on fall.
  logic prev_v = 1'b0;
  int   hi_len = 0;
  always @(posedge top_clk) begin
    exp_t e;
    #1;
    if (dram_valid && !prev_v) begin
      checks++;
      hi_len = 0;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid edge=%0d q=%h", edge_n, dram_q);
      end else begin
        e = exp_q.pop_front();
        if (dram_q !== e.data || edge_n !== e.at) begin
          errors++;
          $display("FAIL read_return got q=%h edge=%0d want q=%h edge=%0d",
                   dram_q, edge_n, e.data, e.at);
        end
      end
    end
    if (dram_valid) hi_len++;
    if (!dram_valid && prev_v) begin
      checks++;
      if (hi_len != 4) begin
        errors++;
        $display("FAIL valid_width got %0d want 4 top cycles", hi_len);
      end
    end
    prev_v = dram_valid;
  end

  // One dram_clk period: 2 top cycles high, 2 low.
  task automatic dedge();
    @(negedge top_clk);
    dram_clk = 1'b1;
    @(posedge top_clk);
    edge_n++;
    @(negedge top_clk);
    @(negedge top_clk);
    dram_clk = 1'b0;
    @(negedge top_clk);
  endtask

  task automatic cmd(input logic c, input logic r, input logic k,
                     input logic [3:0] w, input logic [10:0] ad,
                     input logic [31:0] dd);
    csn  = c;
    rasn = r;
    casn = k;
    wen  = w;
    a    = ad;
    d    = dd;
    dedge();
    csn  = 1'b1;
    rasn = 1'b1;
    casn = 1'b1;
    wen  = 4'hF;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) cmd(1, 1, 1, 4'hF, 0, 0);
  endtask

  task automatic act(input logic [10:0] row);
    cmd(0, 0, 1, 4'hF, row, 0);
  endtask

  task automatic rd(input logic [10:0] col, input logic [31:0] want);
    exp_t e;
    cmd(0, 0, 0, 4'hF, col, 0);
    e.data = want;
    e.at   = edge_n + CAS;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    top_rst = 1'b1;
    repeat (3) @(negedge top_clk);
    checks++;
    if ({dram_valid, row_open, proto_err} !== 3'b000 || dram_q !== 32'h0) begin
      errors++;
      $display("FAIL reset_state got v/ro/pe=%b%b%b q=%h want 000 q=0",
               dram_valid, row_open, proto_err, dram_q);
    end
    top_rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      nop(1);
      checks++;
      if ({dram_valid, row_open, proto_err} !== 3'b000) begin
        errors++;
        $display("FAIL nop_idle got v/ro/pe=%b%b%b want 000",
                 dram_valid, row_open, proto_err);
      end
    end
    checks++;
    if (dram_q !== 32'h0) begin
      errors++;
      $display("FAIL nop_q got %h want 0", dram_q);
    end
  endtask

  task automatic test_write_read();
    act(11'h003);
    checks++;
    if (row_open !== 1'b1) begin
      errors++;
      $display("FAIL activate_row_open got %b want 1", row_open);
    end
    cmd(0, 0, 0, 4'h0, 11'd5, 32'hDEADBEEF);
    rd(11'd5, 32'hDEADBEEF);
    nop(CAS + 2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL write_read_drain got %0d pending want 0", exp_q.size());
    end
    checks++;
    if (dram_q !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL q_hold got %h want deadbeef", dram_q);
    end
  endtask

  task automatic test_byte_merge();
    cmd(0, 0, 0, 4'b1010, 11'd5, 32'h11223344);
    rd(11'd5, 32'hDE22BE44);
    nop(CAS + 2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL byte_merge_drain got %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic test_proto_err();
    cmd(0, 1, 1, 4'hF, 0, 0);
    checks++;
    if (row_open !== 1'b0 || proto_err !== 1'b0) begin
      errors++;
      $display("FAIL precharge got ro/pe=%b%b want 00", row_open, proto_err);
    end
    cmd(0, 0, 0, 4'hF, 11'd5, 0);
    checks++;
    if (proto_err !== 1'b1 || row_open !== 1'b0) begin
      errors++;
      $display("FAIL col_in_idle got pe/ro=%b%b want 10", proto_err, row_open);
    end
    act(11'h003);
    rd(11'd5, 32'hDE22BE44);
    nop(1);
    cmd(0, 0, 0, 4'hF, 11'd6, 0);
    checks++;
    if (proto_err !== 1'b1 || row_open !== 1'b1) begin
      errors++;
      $display("FAIL busy_read got pe/ro=%b%b want 11", proto_err, row_open);
    end
    nop(CAS + 2);
    checks++;
    if (exp_q.size() != 0 || proto_err !== 1'b1) begin
      errors++;
      $display("FAIL busy_drain got pend=%0d pe=%b want 0 1",
               exp_q.size(), proto_err);
    end
  endtask

  task automatic test_snapshot();
    rd(11'd5, 32'hDE22BE44);
    nop(1);
    cmd(0, 0, 0, 4'h0, 11'd5, 32'h0);
    nop(CAS);
    rd(11'd5, 32'h0);
    nop(CAS + 2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL snapshot_drain got %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    cmd(0, 0, 0, 4'h0, 11'd7, 32'hA5A5A5A5);
    rd(11'd7, 32'hA5A5A5A5);
    nop(CAS - 1);
    rd(11'd5, 32'h0);
    nop(CAS + 2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL back_to_back_drain got %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    cmd(0, 0, 0, 4'hF, 11'd7, 0);
    nop(3);
    @(negedge top_clk);
    top_rst = 1'b1;
    repeat (2) @(negedge top_clk);
    top_rst = 1'b0;
    checks++;
    if ({dram_valid, row_open, proto_err} !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset got v/ro/pe=%b%b%b want 000",
               dram_valid, row_open, proto_err);
    end
    nop(CAS + 2);
    act(11'h003);
    rd(11'd7, 32'h0);
    nop(CAS - 1);
    rd(11'd5, 32'h0);
    nop(CAS + 2);
    checks++;
    if (exp_q.size() != 0 || dram_q !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem got pend=%0d q=%h want 0 0",
               exp_q.size(), dram_q);
    end
  endtask

  initial begin
    top_rst  = 1'b1;
    dram_clk = 1'b0;
    csn      = 1'b1;
    rasn     = 1'b1;
    casn     = 1'b1;
    wen      = 4'hF;
    a        = '0;
    d        = '0;
    test_reset();
    test_write_read();
    test_byte_merge();
    test_proto_err();
    test_snapshot();
    test_back_to_back();
    test_reset_mid();
    repeat (4) @(negedge top_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
